ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 176 +++++++++++++++++
 tb/tb_ex_mem_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: 2-entry skid buffer with branch redirect and optional overflow trap.
// Optional feature macro: EX_MEM_OVERFLOW_TRAP_EN (overflow trap on ADD/SUB).
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_z,
  input  logic        alu_of,
  input  logic [31:0] pc,
  input  logic [31:0] branch_target,
  input  logic [4:0]  rd_addr,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] store_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd_addr,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic [31:0] out_store_data,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_valid,
  output logic [31:0] trap_pc
);

  localparam logic [7:0] OP_BEQ = 8'h10;
  localparam logic [7:0] OP_BLE = 8'h15;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] store_data;
    logic [31:0] pc;
  } entry_t;

  state_e      state_q, state_d;
  logic        in_ready_q;
  entry_t      head_q, head_d, tail_q, in_entry;
  logic        head_we, tail_we;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic accept, is_branch, push, pop, redirect_hit, trap_hit;

  always_comb begin
    is_branch    = (alu_op >= OP_BEQ) && (alu_op <= OP_BLE);
    accept       = in_valid && in_ready_q;
    push         = accept && !is_branch && !flush;
    pop          = (state_q != S_EMPTY) && out_ready;
    redirect_hit = accept && is_branch && alu_z && !flush;
  end

`ifdef EX_MEM_OVERFLOW_TRAP_EN
  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;

  logic        trap_valid_q;
  logic [31:0] trap_pc_q;

  // Only the signed ops trap; the unsigned forms wrap silently.
  assign trap_hit = accept && !flush && alu_of && ((alu_op == OP_ADD) || (alu_op == OP_SUB));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_valid_q <= 1'b0;
      trap_pc_q    <= '0;
    end else begin
      trap_valid_q <= trap_hit;
      if (trap_hit) trap_pc_q <= pc;
    end
  end

  assign trap_valid = trap_valid_q;
  assign trap_pc    = trap_pc_q;
`else
  logic unused_alu_of;

  assign unused_alu_of = alu_of;
  assign trap_hit      = 1'b0;
  assign trap_valid    = 1'b0;
  assign trap_pc       = '0;
`endif

  always_comb begin
    in_entry.result     = alu_result;
    in_entry.rd_addr    = rd_addr;
    in_entry.reg_write  = reg_write && !trap_hit;
    in_entry.mem_read   = mem_read;
    in_entry.mem_write  = mem_write && !trap_hit;
    in_entry.store_data = store_data;
    in_entry.pc         = pc;
  end

  // A pop in the flush cycle needs no action: the buffer empties regardless.
  always_comb begin
    state_d = state_q;
    head_d  = in_entry;
    head_we = 1'b0;
    tail_we = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d = S_ONE;
            head_we = 1'b1;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_we = 1'b1;
          end else if (push) begin
            state_d = S_TWO;
            tail_we = 1'b1;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d = S_ONE;
            head_d  = tail_q;
            head_we = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_EMPTY;
      in_ready_q       <= 1'b1;
      head_q           <= '0;
      tail_q           <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      in_ready_q       <= (state_d != S_TWO);
      redirect_valid_q <= redirect_hit;
      if (head_we) head_q <= head_d;
      if (tail_we) tail_q <= in_entry;
      if (redirect_hit) redirect_pc_q <= branch_target;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = (state_q != S_EMPTY);
  assign out_result     = head_q.result;
  assign out_rd_addr    = head_q.rd_addr;
  assign out_reg_write  = head_q.reg_write;
  assign out_mem_read   = head_q.mem_read;
  assign out_mem_write  = head_q.mem_write;
  assign out_store_data = head_q.store_data;
  assign out_pc         = head_q.pc;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios plus random traffic against a queue-based model.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] res;
    logic        z;
    logic        of;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
  } stim_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] sd;
    logic [31:0] pc;
  } ent_t;

`ifdef EX_MEM_OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  stim_t       s = '0;

  logic        in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic [31:0] out_result, out_store_data, out_pc, redirect_pc, trap_pc;
  logic [4:0]  out_rd_addr;
  logic        redirect_valid, trap_valid;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(s.op),
    .alu_result(s.res), .alu_z(s.z), .alu_of(s.of), .pc(s.pc),
    .branch_target(s.tgt), .rd_addr(s.rd), .reg_write(s.rw),
    .mem_read(s.mr), .mem_write(s.mw), .store_data(s.sd),
    .in_ready(in_ready), .out_valid(out_valid), .out_result(out_result),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_store_data(out_store_data), .out_pc(out_pc), .out_ready(out_ready),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t        q[$];
  logic        er = 1'b0, et = 1'b0;
  logic [31:0] erpc = '0, etpc = '0;
  bit          data_zero = 1'b1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("redirect_valid", 32'(redirect_valid), 32'(er));
    chk("redirect_pc", redirect_pc, erpc);
    chk("trap_valid", 32'(trap_valid), 32'(et));
    chk("trap_pc", trap_pc, etpc);
    if (q.size() != 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_rd_addr", 32'(out_rd_addr), 32'(q[0].rd));
      chk("out_reg_write", 32'(out_reg_write), 32'(q[0].rw));
      chk("out_mem_read", 32'(out_mem_read), 32'(q[0].mr));
      chk("out_mem_write", 32'(out_mem_write), 32'(q[0].mw));
      chk("out_store_data", out_store_data, q[0].sd);
      chk("out_pc", out_pc, q[0].pc);
    end else if (data_zero) begin
      chk("reset_out_result", out_result, 32'h0);
      chk("reset_out_pc", out_pc, 32'h0);
      chk("reset_out_store_data", out_store_data, 32'h0);
      chk("reset_out_ctrl", {27'h0, out_rd_addr}, 32'h0);
    end
  endtask

  // Advance one clock: update the model from the inputs now applied, then check after the edge.
  task automatic step();
    bit   acc, pop, br, trp;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      er = 1'b0; erpc = '0; et = 1'b0; etpc = '0;
      data_zero = 1'b1;
    end else begin
      acc = in_valid && (q.size() < 2);
      pop = (q.size() != 0) && out_ready;
      br  = (s.op >= 8'h10) && (s.op <= 8'h15);
      trp = TRAP_EN && acc && ((s.op == 8'h00) || (s.op == 8'h01)) && s.of;
      er = 1'b0;
      et = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc && !br) begin
          e.result = s.res; e.rd = s.rd; e.rw = s.rw && !trp; e.mr = s.mr;
          e.mw = s.mw && !trp; e.sd = s.sd; e.pc = s.pc;
          q.push_back(e);
          data_zero = 1'b0;
        end
        if (acc && br && s.z) begin er = 1'b1; erpc = s.tgt; end
        if (trp) begin et = 1'b1; etpc = s.pc; end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic stim_t mk(input logic [7:0] op, input logic [31:0] res, input logic z,
                               input logic of, input logic [31:0] pc, input logic [31:0] tgt);
    stim_t t;
    t.op = op; t.res = res; t.z = z; t.of = of; t.pc = pc; t.tgt = tgt;
    t.rd = 5'($urandom); t.rw = 1'($urandom); t.mr = 1'($urandom);
    t.mw = 1'($urandom); t.sd = $urandom;
    return t;
  endfunction

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h08;
      3: return 8'h09;
      4: return 8'h10 + 8'($urandom_range(0, 5));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    @(negedge clk);
    // Reset
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Streaming: four back-to-back ADDs
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s = mk(8'h00, 32'(i), 1'b0, 1'b0, 32'h1000 + 32'(4 * i), 32'h0);
      in_valid = 1'b1;
      step();
      chk("stream_result", out_result, 32'(i));
      chk("stream_in_ready", 32'(in_ready), 32'h1);
    end
    in_valid = 1'b0;
    step();
    step();

    // Backpressure: three offered, two accepted, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = mk(8'h08, 32'(10 + i), 1'b0, 1'b0, 32'h2000, 32'h0);
      in_valid = 1'b1;
      step();
    end
    chk("bp_in_ready_full", 32'(in_ready), 32'h0);
    chk("bp_head_held", out_result, 32'd10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_drain_first", out_result, 32'd11);
    step();
    step();

    // Branches
    s = mk(8'h10, 32'hdead_beef, 1'b1, 1'b0, 32'h3000, 32'h0000_0040);
    in_valid = 1'b1;
    step();
    chk("beq_redirect", 32'(redirect_valid), 32'h1);
    chk("beq_redirect_pc", redirect_pc, 32'h40);
    chk("beq_no_output", 32'(out_valid), 32'h0);
    in_valid = 1'b0;
    step();
    chk("beq_pulse_end", 32'(redirect_valid), 32'h0);
    chk("beq_pc_holds", redirect_pc, 32'h40);
    s = mk(8'h11, 32'h1, 1'b0, 1'b0, 32'h3004, 32'h80);
    in_valid = 1'b1;
    step();
    chk("bne_no_redirect", 32'(redirect_valid), 32'h0);
    in_valid = 1'b0;
    step();

    // Flush from TWO with a simultaneous taken branch offered
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = mk(8'h00, 32'(20 + i), 1'b0, 1'b0, 32'h4000, 32'h0);
      in_valid = 1'b1;
      step();
    end
    s = mk(8'h10, 32'h0, 1'b1, 1'b0, 32'h4008, 32'h0000_0400);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_no_redirect", 32'(redirect_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    step();

    // Overflow on signed and unsigned adds
    s = mk(8'h00, 32'h5, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
    s.rw = 1'b1;
    in_valid = 1'b1;
    step();
    chk("trap_reg_write", 32'(out_reg_write), TRAP_EN ? 32'h0 : 32'h1);
    chk("trap_valid", 32'(trap_valid), 32'(TRAP_EN));
    chk("trap_pc", trap_pc, TRAP_EN ? 32'h100 : 32'h0);
    s = mk(8'h08, 32'h6, 1'b0, 1'b1, 32'h0000_0104, 32'h0);
    s.rw = 1'b1;
    step();
    chk("addu_no_trap", 32'(trap_valid), 32'h0);
    chk("addu_reg_write", 32'(out_reg_write), 32'h1);
    s = mk(8'h01, 32'h7, 1'b0, 1'b1, 32'h0000_0108, 32'h0);
    step();
    in_valid = 1'b0;
    step();

    // Reset in TWO, then reset with a redirect pending
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = mk(8'h00, 32'(30 + i), 1'b0, 1'b0, 32'h5000, 32'h0);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    s = mk(8'h00, 32'h40, 1'b0, 1'b0, 32'h6000, 32'h0);
    in_valid = 1'b1;
    step();
    s = mk(8'h12, 32'h0, 1'b1, 1'b0, 32'h6004, 32'h0000_0800);
    step();
    chk("pre_rst_redirect", 32'(redirect_valid), 32'h1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_result", out_result, 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      s = mk(rnd_op(), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 79) != 0);
      step();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
